// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode constants for the IF/ID instruction queue.
// Macro forms are kept for code that still uses the legacy bus defines.
`ifndef InstAddrBus
`define InstAddrBus 63:0
`endif
`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef NopInst
`define NopInst 32'hD503201F
`endif
`ifndef RstEnable
`define RstEnable 1'b0
`endif

package if_id_queue_pkg;
    // ARMv8 NOP, presented to decode as the bubble instruction
    localparam logic [31:0] NOP_INST   = `NopInst;
    localparam logic        RST_ENABLE = `RstEnable;
endpackage

// File: rtl/if_id_fifo_mem.sv
// Register-array storage for the IF/ID queue: one write port, one async read port.
// Contents are never reset; validity is tracked by the pointers in the parent.
module if_id_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction buffer between fetch and decode: small FIFO of {pc, inst} pairs
// with flush support; presents a NOP bubble when empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       if_valid_i,
    input  logic [ADDR_W-1:0]          if_pc_i,
    input  logic [INST_W-1:0]          if_inst_i,
    output logic                       if_ready_o,
    input  logic                       id_ready_i,
    input  logic                       flush_i,
    output logic                       id_valid_o,
    output logic [ADDR_W-1:0]          id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = ADDR_W + INST_W;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] rd_data;

    // Ready and valid depend only on registered occupancy, never on id_ready_i
    assign if_ready_o = (count != CNT_W'(DEPTH));
    assign id_valid_o = (count != '0);
    assign count_o    = count;

    assign push = if_valid_i & if_ready_o & ~flush_i;
    assign pop  = id_valid_o & id_ready_i & ~flush_i;

    always_ff @(posedge clock) begin
        if (reset == RST_ENABLE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({if_pc_i, if_inst_i}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign id_pc_o   = id_valid_o ? rd_data[INST_W +: ADDR_W] : '0;
    assign id_inst_o = id_valid_o ? rd_data[INST_W-1:0]       : INST_W'(NOP_INST);

endmodule
